// File: rtl/tone_period_meter.sv
// Measures period and high time of an asynchronous square-wave tone in CLK100MHZ cycles,
// with a glitch filter, period-to-period lock detection and loss-of-signal timeout.
module tone_period_meter #(
  parameter int SYNC_STAGES    = 2,
  parameter int MIN_PULSE      = 16,
  parameter int CNT_W          = 24,
  parameter int TIMEOUT_CYCLES = 10_000_000,
  parameter int TOL            = 4
) (
  input  logic             CLK100MHZ,
  input  logic             ck_rst,
  input  logic             tone_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             locked,
  output logic             no_signal
);

  localparam int STAB_W = $clog2(MIN_PULSE + 1);
  localparam logic [STAB_W-1:0] STAB_LAST    = STAB_W'(MIN_PULSE - 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W:0]    TOL_W        = (CNT_W + 1)'(TOL);
  localparam logic [CNT_W-1:0]  CNT_ONE      = CNT_W'(1);

  generate
    if (longint'(TIMEOUT_CYCLES) >= (longint'(1) << CNT_W)) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be below 2**CNT_W");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("SYNC_STAGES must be at least 2");
    end
    if (MIN_PULSE < 1) begin : g_bad_pulse
      $error("MIN_PULSE must be at least 1");
    end
  endgenerate

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_MEASURE = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   filt_q, filt_d;
  logic                   filt_prev_q, filt_prev_d;
  logic [STAB_W-1:0]      stab_q, stab_d;
  logic [CNT_W-1:0]       period_cnt_q, period_cnt_d;
  logic [CNT_W-1:0]       high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0]       prev_period_q, prev_period_d;
  logic                   prev_valid_q, prev_valid_d;
  logic [CNT_W-1:0]       period_q, period_d;
  logic [CNT_W-1:0]       high_time_q, high_time_d;
  logic                   period_valid_q, period_valid_d;
  logic                   locked_q, locked_d;
  logic                   no_signal_q, no_signal_d;

  logic                   synced;
  logic                   rise;
  logic [CNT_W-1:0]       period_plus;
  logic [CNT_W:0]         period_diff;

  assign synced = sync_q[SYNC_STAGES-1];
  assign rise   = filt_q & ~filt_prev_q;

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], tone_in};
    filt_d      = filt_q;
    filt_prev_d = filt_q;
    stab_d      = '0;
    // The level only flips once the synced input has disagreed for MIN_PULSE straight cycles.
    if (synced != filt_q) begin
      if (stab_q == STAB_LAST) begin
        filt_d = synced;
        stab_d = '0;
      end else begin
        stab_d = stab_q + 1'b1;
      end
    end else begin
      stab_d = '0;
    end
  end

  always_comb begin
    period_plus = period_cnt_q + CNT_ONE;
    if ({1'b0, period_plus} >= {1'b0, prev_period_q}) begin
      period_diff = {1'b0, period_plus} - {1'b0, prev_period_q};
    end else begin
      period_diff = {1'b0, prev_period_q} - {1'b0, period_plus};
    end
  end

  always_comb begin
    state_d        = state_q;
    period_cnt_d   = period_cnt_q;
    high_cnt_d     = high_cnt_q;
    prev_period_d  = prev_period_q;
    prev_valid_d   = prev_valid_q;
    period_d       = period_q;
    high_time_d    = high_time_q;
    period_valid_d = 1'b0;
    locked_d       = locked_q;
    no_signal_d    = no_signal_q;
    case (state_q)
      S_IDLE: begin
        period_cnt_d = '0;
        high_cnt_d   = '0;
        if (rise) begin
          state_d    = S_MEASURE;
          high_cnt_d = CNT_ONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MEASURE: begin
        // A rise in the same cycle as the timeout wins and is reported.
        if (rise) begin
          period_d       = period_plus;
          high_time_d    = high_cnt_q;
          period_valid_d = 1'b1;
          no_signal_d    = 1'b0;
          locked_d       = prev_valid_q && (period_diff <= TOL_W);
          prev_period_d  = period_plus;
          prev_valid_d   = 1'b1;
          period_cnt_d   = '0;
          high_cnt_d     = CNT_ONE;
        end else if (period_cnt_q == TIMEOUT_LAST) begin
          state_d      = S_IDLE;
          no_signal_d  = 1'b1;
          locked_d     = 1'b0;
          period_d     = '0;
          high_time_d  = '0;
          prev_valid_d = 1'b0;
          period_cnt_d = '0;
          high_cnt_d   = '0;
        end else begin
          period_cnt_d = period_cnt_q + CNT_ONE;
          high_cnt_d   = high_cnt_q + {{(CNT_W-1){1'b0}}, filt_q};
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!ck_rst) begin
      state_q        <= S_IDLE;
      sync_q         <= '0;
      filt_q         <= 1'b0;
      filt_prev_q    <= 1'b0;
      stab_q         <= '0;
      period_cnt_q   <= '0;
      high_cnt_q     <= '0;
      prev_period_q  <= '0;
      prev_valid_q   <= 1'b0;
      period_q       <= '0;
      high_time_q    <= '0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      no_signal_q    <= 1'b1;
    end else begin
      state_q        <= state_d;
      sync_q         <= sync_d;
      filt_q         <= filt_d;
      filt_prev_q    <= filt_prev_d;
      stab_q         <= stab_d;
      period_cnt_q   <= period_cnt_d;
      high_cnt_q     <= high_cnt_d;
      prev_period_q  <= prev_period_d;
      prev_valid_q   <= prev_valid_d;
      period_q       <= period_d;
      high_time_q    <= high_time_d;
      period_valid_q <= period_valid_d;
      locked_q       <= locked_d;
      no_signal_q    <= no_signal_d;
    end
  end

  assign period       = period_q;
  assign high_time    = high_time_q;
  assign period_valid = period_valid_q;
  assign locked       = locked_q;
  assign no_signal    = no_signal_q;

endmodule

// File: tb/tb_tone_period_meter.sv
// Directed and randomized tone stimulus for tone_period_meter, checked against a
// per-period reference model of the tone that was actually generated.
module tb_tone_period_meter;

  localparam int CNT_W   = 24;
  localparam int TIMEOUT = 5000;
  localparam int TOL     = 4;

  logic             clk = 1'b0;
  logic             ck_rst = 1'b0;
  logic             tone_in = 1'b0;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             period_valid;
  logic             locked;
  logic             no_signal;

  tone_period_meter #(
    .SYNC_STAGES(2), .MIN_PULSE(16), .CNT_W(CNT_W), .TIMEOUT_CYCLES(TIMEOUT), .TOL(TOL)
  ) dut (
    .CLK100MHZ(clk), .ck_rst(ck_rst), .tone_in(tone_in), .period(period),
    .high_time(high_time), .period_valid(period_valid), .locked(locked), .no_signal(no_signal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int p;
    int h;
    bit lk;
  } pulse_t;

  pulse_t got_q[$];
  pulse_t exp_q[$];
  int     chk_idx = 0;
  int     n_assert = 0;
  int     n_fail = 0;

  int     cyc = 0;
  int     last_pv_cyc = 0;
  int     ns_rise_cyc = 0;
  logic   ns_prev = 1'b0;

  // model state: the period in progress is (pend_p, pend_h)
  bit     armed = 0;
  bit     have_prev = 0;
  int     prev_p = 0;
  int     pend_p = 0;
  int     pend_h = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (period_valid) begin
      got_q.push_back('{p: int'(period), h: int'(high_time), lk: locked});
      last_pv_cyc <= cyc;
    end
    if (no_signal && !ns_prev) ns_rise_cyc <= cyc;
    ns_prev <= no_signal;
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_rise(input int p, input int h);
    int d;
    if (armed) begin
      d = pend_p - prev_p;
      if (d < 0) d = -d;
      exp_q.push_back('{p: pend_p, h: pend_h, lk: (have_prev && d <= TOL)});
      have_prev = 1;
      prev_p = pend_p;
    end
    armed = 1;
    pend_p = p;
    pend_h = h;
  endtask

  task automatic model_forget();
    armed = 0;
    have_prev = 0;
  endtask

  task automatic drive(input logic v, input int n);
    tone_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic tone(input int p, input int h);
    model_rise(p, h);
    drive(1'b1, h);
    drive(1'b0, p - h);
  endtask

  // 3-cycle low glitch g cycles into the high phase
  task automatic tone_glitch(input int p, input int h, input int g);
    model_rise(p, h);
    drive(1'b1, g);
    drive(1'b0, 3);
    drive(1'b1, h - g - 3);
    drive(1'b0, p - h);
  endtask

  task automatic check_pulses(input string tag);
    int n;
    check({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = chk_idx; i < n; i++) begin
      check({tag, "_period"}, got_q[i].p, exp_q[i].p);
      check({tag, "_high"}, got_q[i].h, exp_q[i].h);
      check({tag, "_locked"}, got_q[i].lk, exp_q[i].lk);
    end
    chk_idx = n;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_period"}, period, 0);
    check({tag, "_high"}, high_time, 0);
    check({tag, "_pv"}, period_valid, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_nosig"}, no_signal, 1);
  endtask

  initial begin
    int p;
    int h;
    int g;

    ck_rst = 1'b0;
    tone_in = 1'b0;
    repeat (5) @(negedge clk);
    check_reset_outputs("reset");
    ck_rst = 1'b1;
    drive(1'b0, 50);

    // 50% square wave, random even period
    p = 2 * $urandom_range(1100, 900);
    for (int i = 0; i < 4; i++) tone(p, p / 2);
    check_pulses("square50");
    check("square50_nosig", no_signal, 0);

    // 25% duty at period 1000
    for (int i = 0; i < 4; i++) tone(1000, 250);
    check_pulses("duty25");

    // period steps 1000 -> 1003 -> 1100
    tone(1003, 500);
    tone(1100, 550);
    check_pulses("step1003");
    tone(1100, 550);
    tone(1100, 550);
    check_pulses("step1100");

    // short low glitches inside the high phase are ignored
    for (int i = 0; i < 3; i++) tone_glitch(2000, 1000, $urandom_range(900, 100));
    tone(2000, 1000);
    check_pulses("glitch");

    // random periods and duties, some repeated for lock
    for (int i = 0; i < 8; i++) begin
      if (i > 0 && $urandom_range(1, 0) == 1) p = pend_p + $urandom_range(6, 0) - 3;
      else p = $urandom_range(3000, 200);
      h = $urandom_range(p - 40, 40);
      if (h >= 60 && $urandom_range(1, 0) == 1) begin
        g = $urandom_range(h - 30, 20);
        tone_glitch(p, h, g);
      end else begin
        tone(p, h);
      end
    end
    check_pulses("random");

    // lock at 1000 then lose the tone
    for (int i = 0; i < 3; i++) tone(1000, 500);
    check_pulses("pre_timeout");
    check("pre_timeout_locked", locked, 1);
    drive(1'b0, TIMEOUT + 200);
    model_forget();
    check("timeout_delay", ns_rise_cyc - last_pv_cyc, TIMEOUT);
    check("timeout_nosig", no_signal, 1);
    check("timeout_locked", locked, 0);
    check("timeout_period", period, 0);
    check("timeout_high", high_time, 0);
    check_pulses("timeout");

    // isolated 1-cycle pulses are never accepted
    for (int i = 0; i < 25; i++) begin
      drive(1'b1, 1);
      drive(1'b0, 127);
    end
    check("spikes_nosig", no_signal, 1);
    check_pulses("spikes");

    // restart: first rise arms only
    for (int i = 0; i < 3; i++) tone(1000, 500);
    check_pulses("restart");
    check("restart_nosig", no_signal, 0);

    // reset for one cycle during the low phase while locked
    model_rise(1000, 500);
    drive(1'b1, 500);
    drive(1'b0, 100);
    check("prereset_locked", locked, 1);
    ck_rst = 1'b0;
    @(negedge clk);
    ck_rst = 1'b1;
    check_reset_outputs("midreset");
    model_forget();
    check_pulses("midreset");
    drive(1'b0, 100);
    for (int i = 0; i < 3; i++) tone(1000, 500);
    drive(1'b0, 50);
    check_pulses("postreset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
